// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier and its add/shift stage.
package shift_add_multiplier_pkg;

   localparam int unsigned DEF_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic int unsigned prod_w(input int unsigned w);
      return 2 * w;
   endfunction

   // One extra bit over clog2 so the iteration counter can index WIDTH itself.
   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

   localparam int unsigned DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/add_shift_stage.sv
// One add-and-shift iteration: ripple-adds the gated multiplicand into acc_hi and
// shifts {carry, sum, mreg} right by one.
module add_shift_stage #(
   parameter int unsigned WIDTH = 6
) (
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mreg,
   output logic [WIDTH-1:0] acc_hi_nxt,
   output logic [WIDTH-1:0] mreg_nxt
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             cout;

   assign addend = mreg[0] ? mcand : '0;

   // Ripple adder with carry-in tied low.
   always_comb begin
      logic c;
      c    = 1'b0;
      sum  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = acc_hi[i] ^ addend[i] ^ c;
         c      = (acc_hi[i] & addend[i]) | (c & (acc_hi[i] ^ addend[i]));
      end
      cout = c;
   end

   assign {acc_hi_nxt, mreg_nxt} = {cout, sum, mreg[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, one partial product per clock with a start/busy/done
// handshake. Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the core).
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned PW    = prod_w(WIDTH);
   localparam int unsigned CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mreg_q, mreg_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PW-1:0]    product_q, product_d;

   logic [WIDTH-1:0] acc_hi_nxt, mreg_nxt;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    result;
   logic             load, last_iter;

   assign load      = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign last_iter = (state_q == ST_RUN) && (count_q == LAST_CNT);

`ifdef MUL_SIGNED_EN
   logic neg_q, neg_d;
   logic signed [WIDTH-1:0] a_s, b_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = v;
      if (v[WIDTH-1])
         r = ~r + WIDTH'(1);
      return r;
   endfunction

   function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
      return ~v + PW'(1);
   endfunction

   assign a_s    = a;
   assign b_s    = b;
   assign a_mag  = magnitude(a_s);
   assign b_mag  = magnitude(b_s);
   assign neg_d  = load ? (a_s[WIDTH-1] ^ b_s[WIDTH-1]) : neg_q;
   assign result = neg_q ? negate({acc_hi_nxt, mreg_nxt}) : {acc_hi_nxt, mreg_nxt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         neg_q <= 1'b0;
      else
         neg_q <= neg_d;
   end
`else
   assign a_mag  = a;
   assign b_mag  = b;
   assign result = {acc_hi_nxt, mreg_nxt};
`endif

   add_shift_stage #(.WIDTH(WIDTH)) u_add_shift_stage (
      .acc_hi     (acc_hi_q),
      .mcand      (mcand_q),
      .mreg       (mreg_q),
      .acc_hi_nxt (acc_hi_nxt),
      .mreg_nxt   (mreg_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         mreg_q    <= '0;
         acc_hi_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mreg_q    <= mreg_d;
         acc_hi_q  <= acc_hi_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_iter) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Starts arriving during RUN fall through untouched: load is only true in IDLE/DONE.
   always_comb begin
      mcand_d   = mcand_q;
      mreg_d    = mreg_q;
      acc_hi_d  = acc_hi_q;
      count_d   = count_q;
      product_d = product_q;
      if (load) begin
         mcand_d  = a_mag;
         mreg_d   = b_mag;
         acc_hi_d = '0;
         count_d  = '0;
      end else if (state_q == ST_RUN) begin
         acc_hi_d = acc_hi_nxt;
         mreg_d   = mreg_nxt;
         count_d  = count_q + CNT_W'(1);
         if (last_iter)
            product_d = result;
      end
   end

   always_comb begin
      busy    = (state_q == ST_RUN);
      done    = (state_q == ST_DONE);
      product = product_q;
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier; signed vectors are used when MUL_SIGNED_EN is defined.
module tb_shift_add_multiplier;

   localparam int W = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [W-1:0]    a_i, b_i;
   logic            busy, done;
   logic [2*W-1:0]  product;

   int checks = 0;
   int errors = 0;
   int n, cnt;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a_i),
      .b       (b_i),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges counted until done is seen, capped at 20.
   task automatic wait_done(output int edges);
      edges = 0;
      do begin
         tick();
         edges++;
      end while (!done && edges < 20);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [31:0] exp, input logic [31:0] prev);
      int lat;
      a_i   = av;
      b_i   = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_held"}, product, prev);
      wait_done(lat);
      chk({tag, "_lat"}, lat, W);
      chk({tag, "_prod"}, product, exp);
      tick();
      chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      repeat (2) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prod", product, 0);
      rst_n = 1'b1;
      tick();

`ifdef MUL_SIGNED_EN
      do_op("s_m32m32", 6'b100000, 6'b100000, 32'h400, 32'h0);
      do_op("s_m1p5",   6'b111111, 6'd5,      32'hFFB, 32'h400);
      do_op("s_31m32",  6'd31,     6'b100000, 32'hC20, 32'hFFB);
`else
      do_op("max",  6'd63, 6'd63, 32'd3969, 32'd0);
      do_op("zero", 6'd0,  6'd45, 32'd0,    32'd3969);
      do_op("one",  6'd1,  6'd45, 32'd45,   32'd0);
`endif

      // Second start two cycles into the operation must be ignored.
      a_i = 6'd5; b_i = 6'd7; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a_i = 6'd63; b_i = 6'd63; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign_busy", busy, 1);
      wait_done(n);
      chk("ign_lat", n, 3);
      chk("ign_prod", product, 35);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) cnt++;
      end
      chk("ign_extra", cnt, 0);
      chk("ign_hold", product, 35);

      // Back-to-back with start held high.
      a_i = 6'd3; b_i = 6'd4; start = 1'b1;
      tick();
      wait_done(n);
      chk("b2b_lat1", n, W);
      chk("b2b_prod1", product, 12);
      a_i = 6'd10; b_i = 6'd10;
      wait_done(n);
      chk("b2b_gap", n, W + 1);
      chk("b2b_prod2", product, 100);
      start = 1'b0;
      tick();
      chk("b2b_idle", done, 0);
      chk("b2b_nobusy", busy, 0);

      // Asynchronous reset mid-operation.
      a_i = 6'd20; b_i = 6'd30; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("mid_busy_pre", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_prod", product, 0);
      #3 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy) cnt++;
      end
      chk("mid_idle", cnt, 0);
      chk("mid_prod_hold", product, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
